// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   - state_t       : sequencer FSM states (HOLD, RELEASE, RUN)
//   - *_MAX         : largest legal value of each counted quantity
//   - cnt_w()       : width of a counter that must hold values 0..max_val
// No ports (package).
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Upper bounds of the quantities the counters track.
  localparam int HOLD_CYCLES_MAX = 65535;
  localparam int GAP_CYCLES_MAX  = 255;
  localparam int NUM_OUT_MAX     = 16;
  localparam int IDX_MAX         = NUM_OUT_MAX - 1;

  // $clog2(max)+1 bits always hold the value max itself, so a counter sized
  // this way can sit at its terminal value without wrapping.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/req_sync.sv
// -----------------------------------------------------------------------------
// req_sync
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input level
//   q   : synchronized level, SYNC_STAGES cycles behind d
// -----------------------------------------------------------------------------
module req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Holds NUM_OUT downstream resets asserted until the request has been low for
// HOLD_CYCLES consecutive cycles, then releases them one at a time (bit 0
// first) every GAP_CYCLES cycles. Any request re-asserts all outputs.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset
//   req_i  : asynchronous, level-sensitive reset request (active-high)
//   rst_o  : per-domain resets, active-high, straight from flops
//   busy_o : high while any rst_o bit is high
//   done_o : one-cycle pulse on the cycle the last rst_o bit falls
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUT     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  output logic [NUM_OUT-1:0] rst_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int GAP_W  = cnt_w(GAP_CYCLES);
  localparam int IDX_W  = cnt_w(NUM_OUT - 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] ALL_ONES  = '1;

  logic req_s;

  req_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .clk(clk),
    .rst(rst),
    .d  (req_i),
    .q  (req_s)
  );

  state_t              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_reg,  hold_next;
  logic [GAP_W-1:0]    gap_reg,   gap_next;
  logic [IDX_W-1:0]    idx_reg,   idx_next;
  logic [NUM_OUT-1:0]  rst_reg,   rst_next;
  logic                done_reg,  done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HOLD;
      hold_reg  <= '0;
      gap_reg   <= '0;
      idx_reg   <= '0;
      rst_reg   <= '1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      gap_reg   <= gap_next;
      idx_reg   <= idx_next;
      rst_reg   <= rst_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    gap_next   = gap_reg;
    idx_next   = idx_reg;
    rst_next   = rst_reg;
    done_next  = 1'b0;

    case (state_reg)
      HOLD: begin
        rst_next = '1;
        gap_next = '0;
        idx_next = '0;
        if (req_s) begin
          hold_next = '0;
        end else begin
          if (hold_reg < HOLD_LAST) begin
            hold_next = hold_reg + 1'b1;
          end
          // The release is registered on the same edge the counter reaches
          // its target, so rst_o[0] is already low in that cycle.
          if (hold_next == HOLD_LAST) begin
            hold_next = '0;
            rst_next  = ALL_ONES << 1;
            if (NUM_OUT == 1) begin
              done_next  = 1'b1;
              state_next = RUN;
            end else begin
              state_next = RELEASE;
            end
          end
        end
      end

      RELEASE: begin
        if (req_s) begin
          state_next = HOLD;
          rst_next   = '1;
          hold_next  = '0;
          gap_next   = '0;
          idx_next   = '0;
        end else begin
          if (gap_reg < GAP_LAST) begin
            gap_next = gap_reg + 1'b1;
          end
          if (gap_next == GAP_LAST) begin
            gap_next = '0;
            if (idx_reg < IDX_LAST) begin
              idx_next = idx_reg + 1'b1;
            end
            // Released bits form a contiguous low run from bit 0, so one
            // more release is a left shift.
            rst_next = rst_reg << 1;
            if (idx_next == IDX_LAST) begin
              done_next  = 1'b1;
              state_next = RUN;
            end
          end
        end
      end

      RUN: begin
        rst_next = '0;
        if (req_s) begin
          state_next = HOLD;
          rst_next   = '1;
          hold_next  = '0;
        end
      end

      default: begin
        state_next = HOLD;
        rst_next   = '1;
        hold_next  = '0;
        gap_next   = '0;
        idx_next   = '0;
      end
    endcase
  end

  assign rst_o  = rst_reg;
  assign busy_o = |rst_reg;
  assign done_o = done_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       req_i;
  logic [3:0] rst_o;
  logic       busy_o;
  logic       done_o;
  logic [0:0] rst1_o;
  logic       busy1_o;
  logic       done1_o;

  int tests_run;
  int tests_failed;
  int cyc;

  reset_sequencer #(
    .NUM_OUT    (4),
    .SYNC_STAGES(2),
    .HOLD_CYCLES(16),
    .GAP_CYCLES (4)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i),
    .rst_o (rst_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  reset_sequencer #(
    .NUM_OUT    (1),
    .SYNC_STAGES(2),
    .HOLD_CYCLES(1),
    .GAP_CYCLES (1)
  ) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .req_i (req_i),
    .rst_o (rst1_o),
    .busy_o(busy1_o),
    .done_o(done1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Release pattern of the default instance, counted from the first cycle of
  // an undisturbed HOLD with the request low.
  function automatic logic [3:0] exp_rst(input int rel);
    if (rel < 16)      return 4'b1111;
    else if (rel < 20) return 4'b1110;
    else if (rel < 24) return 4'b1100;
    else if (rel < 28) return 4'b1000;
    else               return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests_run++;
    assert (got === exp)
    else begin
      tests_failed++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // Checks all three outputs of the default instance.
  task automatic chk_main(input string tag, input logic [3:0] e_rst, input logic e_done);
    chk({tag, ".rst_o"}, rst_o, e_rst);
    chk({tag, ".busy_o"}, {3'b000, busy_o}, {3'b000, (e_rst != 4'b0000)});
    chk({tag, ".done_o"}, {3'b000, done_o}, {3'b000, e_done});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk_main("reset", 4'b1111, 1'b0);
      chk("reset.rst1_o", {3'b000, rst1_o}, 4'b0001);
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst          = 1'b1;
    req_i        = 1'b0;

    // Power-up release, then a one-cycle request while running.
    do_reset();
    for (int c = 0; c <= 76; c++) begin
      cyc   = c;
      req_i = (c == 40);
      if (c < 41)      chk_main("powerup", exp_rst(c), c == 28);
      else if (c < 43) chk_main("run", 4'b0000, 1'b0);
      else             chk_main("rerelease", exp_rst(c - 43), (c - 43) == 28);
      if (c <= 39) begin
        chk("edge.rst1_o", {3'b000, rst1_o}, {3'b000, (c == 0)});
        chk("edge.done1_o", {3'b000, done1_o}, {3'b000, (c == 1)});
      end
      next_cycle();
    end
    req_i = 1'b0;
    $display("[TB] powerup/run-request sequence checked through cycle 76");

    // Request arriving partway through the release.
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      cyc   = c;
      req_i = (c == 21);
      if (c < 24) chk_main("abort", exp_rst(c), 1'b0);
      else        chk_main("abort.restart", exp_rst(c - 24), (c - 24) == 28);
      next_cycle();
    end
    req_i = 1'b0;
    $display("[TB] abort mid-release checked through cycle 60");

    // Periodic requests keep restarting the hold count.
    do_reset();
    for (int c = 0; c <= 99; c++) begin
      cyc   = c;
      req_i = ((c % 10) == 0);
      chk_main("holdrestart", 4'b1111, 1'b0);
      next_cycle();
    end
    req_i = 1'b0;
    $display("[TB] periodic hold restart checked through cycle 99");

    // Reset pulse partway through the release replays the power-up sequence.
    do_reset();
    for (int c = 0; c <= 60; c++) begin
      cyc = c;
      rst = (c == 22);
      if (c <= 22) chk_main("midrst", exp_rst(c), 1'b0);
      else         chk_main("midrst.replay", exp_rst(c - 23), (c - 23) == 28);
      next_cycle();
    end
    rst = 1'b0;
    $display("[TB] reset mid-sequence checked through cycle 60");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_OUT, default 4: number of reset outputs released in order; legal range 1..16.
REQ-002 Parameter SYNC_STAGES, default 2: request synchronizer depth; legal range 2..4.
REQ-003 Parameter HOLD_CYCLES, default 16: consecutive request-low cycles required before the first release; legal range 1..65535.
REQ-004 Parameter GAP_CYCLES, default 4: cycles between successive releases; legal range 1..255.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req_i  input  1  reset request, level, active-high, asynchronous to clk.
REQ-008 rst_o  output  NUM_OUT  per-domain reset, active-high; drives downstream register rst pins.
REQ-009 busy_o  output  1  high whenever any rst_o bit is high.
REQ-010 done_o  output  1  one-cycle pulse when the release sequence completes.

Function
REQ-011 req_i SHALL pass through a SYNC_STAGES-deep flop chain before use; the synchronized value is req_s.
REQ-012 FSM states SHALL be: HOLD, RELEASE, RUN.
REQ-013 HOLD: all rst_o = 1; hold counter increments each cycle req_s = 0 and clears to 0 on any cycle req_s = 1.
REQ-014 HOLD -> RELEASE when the hold counter reaches HOLD_CYCLES; rst_o[0] SHALL read 0 from that cycle.
REQ-015 RELEASE: rst_o[i] SHALL fall exactly GAP_CYCLES cycles after rst_o[i-1] falls; a gap counter and an index counter track progress.
REQ-016 Once deasserted, an rst_o bit SHALL stay 0 until the next assertion event.
REQ-017 When rst_o[NUM_OUT-1] falls, done_o SHALL be 1 for that single cycle only, and the FSM SHALL enter RUN.
REQ-018 When NUM_OUT = 1, REQ-017 coincides with REQ-014: done_o pulses in the same cycle that rst_o[0] falls.
REQ-019 RUN: rst_o = 0 and busy_o = 0; req_s = 1 -> all rst_o = 1 on the next cycle, and the FSM enters HOLD with the hold counter at 0.
REQ-020 req_s = 1 during RELEASE SHALL reassert all rst_o on the next cycle, enter HOLD, and clear the hold, gap, and index counters; no done_o is issued.
REQ-021 Latency from req_i rising (first sampling edge) to all rst_o = 1 SHALL be SYNC_STAGES+1 cycles, measured from RUN.
REQ-022 rst_o bits SHALL be driven directly from flops, with no combinational path from req_i or from the counters.
REQ-023 Counter widths SHALL be sized as $clog2 of their maximum value plus 1; the counters SHALL saturate and never wrap.

Reset
REQ-024 rst = 1 SHALL force: state HOLD, rst_o all 1, busy_o 1, done_o 0, all counters 0, synchronizer flops 0.
REQ-025 rst asserted in any state SHALL take effect at the next clock edge; the sequence SHALL restart from HOLD after rst falls.
REQ-026 rst_o SHALL be 1 during every cycle in which rst = 1.

Structure
REQ-027 A shared package reset_seq_pkg SHALL hold the state enum (HOLD, RELEASE, RUN) and the maximum-value constants for the counters.
REQ-028 The request synchronizer SHALL be a separate sub-module, req_sync, parameterized by SYNC_STAGES, with ports clk, rst, d, q.
REQ-029 Expected implementation size: 150-250 lines total.

Verification
(Cycle 0 is the first cycle with rst = 0; defaults apply unless stated.)
REQ-030 Power-up: rst high for 3 cycles, then low, req_i = 0 -> rst_o falls 4'b1110 at cycle 16, 4'b1100 at 20, 4'b1000 at 24, 4'b0000 at 28; done_o is 1 only at cycle 28; busy_o falls at 28.
REQ-031 Request in RUN: req_i pulse high for 1 cycle at cycle 40 -> rst_o = 4'b1111 at cycle 43, then the release sequence repeats with the last release 16+12 cycles after req_s falls.
REQ-032 Abort mid-release: req_i high at cycle 21 -> rst_o = 4'b1111 by cycle 24, with no done_o; the release restarts HOLD_CYCLES after req_s returns low.
REQ-033 Hold restart: req_i toggled high for 1 cycle every 10 cycles -> rst_o stays 4'b1111 and done_o stays 0 indefinitely.
REQ-034 Reset mid-sequence: rst pulsed at cycle 22 -> rst_o = 4'b1111 on the next edge, and the sequence replays exactly as in REQ-030 relative to the new rst release.
REQ-035 Edge parameters: NUM_OUT = 1, HOLD_CYCLES = 1, GAP_CYCLES = 1 -> rst_o falls and done_o pulses at cycle 1, with no further toggles.
